// File: rtl/hue_pkg.sv
// Shared types and per-phase lookups for the hue wheel sequencer.
package hue_pkg;

    typedef enum logic [2:0] {
        RISE_G = 3'd0,
        FALL_R = 3'd1,
        RISE_B = 3'd2,
        FALL_G = 3'd3,
        RISE_R = 3'd4,
        FALL_B = 3'd5,
        IDLE   = 3'd7
    } phase_t;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    // Channel that moves during a phase (IDLE maps to B but is never stepped).
    function automatic logic [1:0] active_chan(input phase_t p);
        case (p)
            RISE_G, FALL_G: return CH_G;
            FALL_R, RISE_R: return CH_R;
            default:        return CH_B;
        endcase
    endfunction

    // 1 when the active channel counts up towards full-on.
    function automatic logic rising(input phase_t p);
        return (p == RISE_G) || (p == RISE_B) || (p == RISE_R);
    endfunction

    // Phase entered once the active channel lands on its target.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            RISE_G:  return FALL_R;
            FALL_R:  return RISE_B;
            RISE_B:  return FALL_G;
            FALL_G:  return RISE_R;
            RISE_R:  return FALL_B;
            FALL_B:  return RISE_G;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/hue_sequencer_if.sv
// Control and duty/status bundle between the sequencer and its consumer.
interface hue_sequencer_if #(
    parameter int unsigned W = 11
);
    logic         enable;
    logic         hold;
    logic [W-1:0] pwm_r;
    logic [W-1:0] pwm_g;
    logic [W-1:0] pwm_b;
    logic [2:0]   phase;
    logic         wheel_done;

    modport master (
        input  enable, hold,
        output pwm_r, pwm_g, pwm_b, phase, wheel_done
    );

    modport slave (
        output enable, hold,
        input  pwm_r, pwm_g, pwm_b, phase, wheel_done
    );
endinterface

// File: rtl/pwm.sv
// Single-channel PWM: output high while the period counter is below duty.
// duty == PWM_INTERVAL gives a constant high output.
module pwm #(
    parameter int unsigned PWM_INTERVAL = 1200
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [$clog2(PWM_INTERVAL)-1:0] duty,
    output logic                            pwm_out
);
    localparam int unsigned W = $clog2(PWM_INTERVAL);
    localparam logic [W-1:0] LAST = W'(PWM_INTERVAL - 1);

    logic [W-1:0] cnt;

    // Period counter and registered compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            pwm_out <= 1'b0;
        end else begin
            cnt     <= (cnt == LAST) ? '0 : cnt + W'(1);
            pwm_out <= (cnt < duty);
        end
    end

endmodule

// File: rtl/step_timer.sv
// Prescaler: counts 0..STEP_CYCLES-1 and flags the wrap cycle as a tick.
// hold freezes the count; clear forces it back to zero.
module step_timer #(
    parameter int unsigned STEP_CYCLES = 12000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic hold,
    output logic tick
);
    localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Free-running wrap counter; a frozen count keeps a pending tick alive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST) && !hold && !clear;

endmodule

// File: rtl/hue_sequencer.sv
// Colour-wheel fade controller: steps R/G/B duties through six hue phases
// and drives three PWM channels onto active-low LED pins.
module hue_sequencer
    import hue_pkg::*;
#(
    parameter int unsigned PWM_INTERVAL = 1200,
    parameter int unsigned STEP_SIZE    = 10,
    parameter int unsigned STEP_CYCLES  = 12000
) (
    input  logic              clk,
    input  logic              rst_n,
    hue_sequencer_if.master   bus,
    output logic              led_r_n,
    output logic              led_g_n,
    output logic              led_b_n
);
    localparam int unsigned W = $clog2(PWM_INTERVAL);
    localparam logic [W-1:0] FULL = W'(PWM_INTERVAL);
    localparam logic [W-1:0] STEP = W'(STEP_SIZE);

    phase_t       state_q, state_d;
    logic [W-1:0] duty_q [3];
    logic [W-1:0] duty_d [3];
    logic         done_q, done_d;
    logic         clear, tick;
    logic [1:0]   ch;
    logic         up;
    logic [W-1:0] moved;
    logic         pwm_out_r, pwm_out_g, pwm_out_b;

    // Timer restarts from zero whenever the wheel is (re)entered.
    assign clear = !bus.enable || (state_q == IDLE);

    step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .hold  (bus.hold),
        .tick  (tick)
    );

    // Next phase, duties and wheel pulse; disable beats hold, hold beats tick.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        done_d  = 1'b0;
        ch      = active_chan(state_q);
        up      = rising(state_q);
        moved   = '0;
        if (!bus.enable) begin
            state_d = IDLE;
            duty_d  = '{default: '0};
        end else if (!bus.hold) begin
            if (state_q == IDLE) begin
                state_d      = RISE_G;
                duty_d[CH_R] = FULL;
                duty_d[CH_G] = '0;
                duty_d[CH_B] = '0;
            end else if (tick) begin
                moved      = up ? duty_q[ch] + STEP : duty_q[ch] - STEP;
                duty_d[ch] = moved;
                if (moved == (up ? FULL : '0)) begin
                    state_d = next_phase(state_q);
                    done_d  = (state_q == FALL_B);
                end
            end
        end
    end

    // Phase, duty and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            duty_q  <= '{default: '0};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            done_q  <= done_d;
        end
    end

    assign bus.pwm_r      = duty_q[CH_R];
    assign bus.pwm_g      = duty_q[CH_G];
    assign bus.pwm_b      = duty_q[CH_B];
    assign bus.phase      = state_q;
    assign bus.wheel_done = done_q;

    pwm #(.PWM_INTERVAL(PWM_INTERVAL)) u_pwm_r (
        .clk(clk), .rst_n(rst_n), .duty(duty_q[CH_R]), .pwm_out(pwm_out_r)
    );
    pwm #(.PWM_INTERVAL(PWM_INTERVAL)) u_pwm_g (
        .clk(clk), .rst_n(rst_n), .duty(duty_q[CH_G]), .pwm_out(pwm_out_g)
    );
    pwm #(.PWM_INTERVAL(PWM_INTERVAL)) u_pwm_b (
        .clk(clk), .rst_n(rst_n), .duty(duty_q[CH_B]), .pwm_out(pwm_out_b)
    );

    assign led_r_n = ~pwm_out_r;
    assign led_g_n = ~pwm_out_g;
    assign led_b_n = ~pwm_out_b;

endmodule

// File: tb/tb_hue_sequencer.sv
// Scoreboard bench for hue_sequencer with small parameters (6/2/3).
module tb_hue_sequencer;
    localparam int unsigned PWM_INTERVAL = 6;
    localparam int unsigned STEP_SIZE    = 2;
    localparam int unsigned STEP_CYCLES  = 3;
    localparam int unsigned W = $clog2(PWM_INTERVAL);

    logic clk = 1'b0;
    logic rst_n;
    logic led_r_n, led_g_n, led_b_n;

    hue_sequencer_if #(.W(W)) bus ();

    hue_sequencer #(
        .PWM_INTERVAL(PWM_INTERVAL),
        .STEP_SIZE   (STEP_SIZE),
        .STEP_CYCLES (STEP_CYCLES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .led_r_n (led_r_n),
        .led_g_n (led_g_n),
        .led_b_n (led_b_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        string name;
        int    r, g, b, ph, done, lr, lb;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int done_pulses = 0;

    // Per-step (r,g,b,phase) after each of the 18 ticks of one wheel.
    int step_r [18] = '{6,6,6, 4,2,0, 0,0,0, 0,0,0, 2,4,6, 6,6,6};
    int step_g [18] = '{2,4,6, 6,6,6, 6,6,6, 4,2,0, 0,0,0, 0,0,0};
    int step_b [18] = '{0,0,0, 0,0,0, 2,4,6, 6,6,6, 6,6,6, 4,2,0};
    int step_ph[18] = '{0,0,1, 1,1,2, 2,2,3, 3,3,4, 4,4,5, 5,5,0};

    function automatic void push(input int c, input string n, input int r, input int g,
                                 input int b, input int ph, input int done,
                                 input int lr = -1, input int lb = -1);
        exp_t e;
        e.cyc = c; e.name = n; e.r = r; e.g = g; e.b = b;
        e.ph = ph; e.done = done; e.lr = lr; e.lb = lb;
        sb.push_back(e);
    endfunction

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compare every expectation due on this cycle.
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            if (bus.wheel_done) done_pulses++;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                vectors++;
                ok = (e.cyc == cyc)
                  && (int'(bus.pwm_r) == e.r) && (int'(bus.pwm_g) == e.g)
                  && (int'(bus.pwm_b) == e.b) && (int'(bus.phase) == e.ph)
                  && (int'(bus.wheel_done) == e.done)
                  && (e.lr < 0 || int'(led_r_n) == e.lr)
                  && (e.lb < 0 || int'(led_b_n) == e.lb);
                if (!ok) begin
                    miscompares++;
                    $display("FAIL %s @cyc %0d (due %0d): got r=%0d g=%0d b=%0d ph=%0d done=%0d ledr=%0d ledb=%0d, want r=%0d g=%0d b=%0d ph=%0d done=%0d ledr=%0d ledb=%0d",
                             e.name, cyc, e.cyc, bus.pwm_r, bus.pwm_g, bus.pwm_b, bus.phase,
                             bus.wheel_done, led_r_n, led_b_n,
                             e.r, e.g, e.b, e.ph, e.done, e.lr, e.lb);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, t0, t1, t2, h0;
        int pr, pg, pb, pp;
        rst_n = 1'b0;
        bus.enable = 1'b0;
        bus.hold = 1'b0;

        // Reset, then release with enable low.
        @(negedge clk);
        c = cyc;
        push(c + 1, "reset", 0, 0, 0, 7, 0, 1, 1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        push(c + 2, "idle_disabled", 0, 0, 0, 7, 0);
        push(c + 3, "idle_disabled", 0, 0, 0, 7, 0);
        wait_cyc(c + 3);

        // Start and one full wheel.
        bus.enable = 1'b1;
        t0 = cyc + 1;
        push(t0, "start", 6, 0, 0, 0, 0);
        for (int k = 0; k < 18; k++) begin
            if (k == 0) begin
                pr = 6; pg = 0; pb = 0; pp = 0;
            end else begin
                pr = step_r[k-1]; pg = step_g[k-1]; pb = step_b[k-1]; pp = step_ph[k-1];
            end
            push(t0 + 3*k + 2, "pre_step", pr, pg, pb, pp, 0,
                 (k == 2) ? 0 : -1, (k == 2) ? 1 : -1);
            push(t0 + 3*k + 3, "step", step_r[k], step_g[k], step_b[k], step_ph[k],
                 (k == 17) ? 1 : 0);
        end
        push(t0 + 55, "done_clear", 6, 0, 0, 0, 0);
        wait_cyc(t0 + 56);
        vectors++;
        if (done_pulses != 1) begin
            miscompares++;
            $display("FAIL wheel_done_count: got %0d pulses, want 1", done_pulses);
        end

        // Hold for 10 cycles right after g reaches 2.
        push(t0 + 57, "hold_entry", 6, 2, 0, 0, 0);
        wait_cyc(t0 + 57);
        bus.hold = 1'b1;
        h0 = cyc;
        for (int i = 1; i <= 12; i++) push(h0 + i, "hold_frozen", 6, 2, 0, 0, 0);
        push(h0 + 13, "hold_resume", 6, 4, 0, 0, 0);
        wait_cyc(h0 + 10);
        bus.hold = 1'b0;
        wait_cyc(h0 + 13);

        // Hold across a pending tick; it must fire right after release.
        for (int i = 14; i <= 18; i++) push(h0 + i, "hold_pending", 6, 4, 0, 0, 0);
        push(h0 + 19, "pending_tick", 6, 6, 0, 1, 0);
        wait_cyc(h0 + 15);
        bus.hold = 1'b1;
        wait_cyc(h0 + 18);
        bus.hold = 1'b0;
        wait_cyc(h0 + 19);

        // Disable overrides everything.
        bus.enable = 1'b0;
        push(h0 + 20, "disable", 0, 0, 0, 7, 0);
        push(h0 + 21, "disable", 0, 0, 0, 7, 0);
        wait_cyc(h0 + 21);

        // Disable mid-FALL_G, then re-enable.
        bus.enable = 1'b1;
        t1 = cyc + 1;
        push(t1,      "restart",      6, 0, 0, 0, 0);
        push(t1 + 27, "enter_fall_g", 0, 6, 6, 3, 0);
        push(t1 + 30, "fall_g_step",  0, 4, 6, 3, 0);
        push(t1 + 31, "fall_g_step",  0, 4, 6, 3, 0);
        push(t1 + 32, "disable_mid",  0, 0, 0, 7, 0);
        push(t1 + 33, "disable_mid",  0, 0, 0, 7, 0);
        wait_cyc(t1 + 31);
        bus.enable = 1'b0;
        wait_cyc(t1 + 33);
        bus.enable = 1'b1;
        t2 = cyc + 1;
        push(t2,      "reenable",      6, 0, 0, 0, 0);
        push(t2 + 2,  "reenable_wait", 6, 0, 0, 0, 0);
        push(t2 + 3,  "reenable_step", 6, 2, 0, 0, 0);
        push(t2 + 21, "rise_b_step",   0, 6, 2, 2, 0);

        // Async reset pulse between edges during RISE_B.
        wait_cyc(t2 + 21);
        push(t2 + 22, "async_reset", 0, 0, 0, 7, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        push(t2 + 23, "post_reset_start", 6, 0, 0, 0, 0);
        drain();

        bus.enable = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
